// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch channel, the load/store channel and the
// shared memory port of the arbiter.
// Signals:
//   if_req/if_addr -> if_gnt/if_rvalid/if_rdata            fetch channel
//   d_req/d_we/d_addr/d_wdata/d_wstrb -> d_gnt/d_rvalid/d_rdata   data channel
//   mem_en/mem_we/mem_wstrb/mem_addr/mem_wdata -> mem_rdata       memory port
// Modports:
//   master - the arbiter: takes requests, drives grants, responses and the memory port
//   slave  - the core and the memory around it
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_wstrb;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one fixed-latency memory port
// between the fetch stage and the load/store unit, one transaction at a time.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset; every output is 0 while it is low
//   bus   - mem_arbiter_if.master: fetch and data request/response channels
//           plus the memory port
// Parameters: AW address width, DW data width (32), MEM_LAT read latency 1..4.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input logic           clk,
    input logic           rst_n,
    mem_arbiter_if.master bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       is_wr_q, is_wr_d;
    logic [2:0] lat_cnt_q, lat_cnt_d;

    logic          d_wins, issue, done, wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;

    // owner/last encode 1 = data port, 0 = fetch port; on a tie the port that
    // did not win last time goes first.
    assign d_wins = bus.d_req && !(bus.if_req && last_q);
    assign issue  = rst_n && state_q == IDLE && (bus.if_req || bus.d_req);
    assign done   = rst_n && state_q == BUSY && lat_cnt_q == 3'(MEM_LAT);
    assign wr     = issue && d_wins && bus.d_we;
    assign addr   = d_wins ? bus.d_addr : bus.if_addr;
    assign wdata  = bus.d_wdata;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        is_wr_d   = is_wr_q;
        lat_cnt_d = lat_cnt_q;
        if (issue) begin
            state_d   = BUSY;
            owner_d   = d_wins;
            last_d    = d_wins;
            is_wr_d   = wr;
            lat_cnt_d = 3'd1;
        end else if (done) begin
            state_d = IDLE;
        end else if (state_q == BUSY) begin
            lat_cnt_d = lat_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b0;
            is_wr_q   <= 1'b0;
            lat_cnt_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            is_wr_q   <= is_wr_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    assign bus.if_gnt    = issue && !d_wins;
    assign bus.d_gnt     = issue && d_wins;
    assign bus.mem_en    = issue;
    assign bus.mem_we    = wr;
    assign bus.mem_wstrb = wr ? bus.d_wstrb : 4'b0000;
    assign bus.mem_addr  = issue ? addr : '0;
    assign bus.mem_wdata = wr ? wdata : '0;
    assign bus.if_rvalid = done && !owner_q;
    assign bus.d_rvalid  = done && owner_q;
    // Stores are acknowledged with zero data; the memory read bus is ignored.
    assign bus.if_rdata  = (done && !owner_q) ? bus.mem_rdata : '0;
    assign bus.d_rdata   = (done && owner_q && !is_wr_q) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench running the same directed sequence against
// four arbiter instances with MEM_LAT = 1..4.
module tb_mem_arbiter;
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] data;
    } ev_t;

    localparam logic [1:0] KIF_G = 2'd0, KD_G = 2'd1, KIF_R = 2'd2, KD_R = 2'd3;

    logic clk = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   done  = 0;

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string what);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s", what);
        end
    endtask

    function automatic string fmt(input ev_t e);
        string k;
        k = e.kind == KIF_G ? "if_gnt" : e.kind == KD_G ? "d_gnt" : e.kind == KIF_R ? "if_rvalid" : "d_rvalid";
        return $sformatf("%s@%0d addr=%h we=%b strb=%b data=%h", k, e.cyc, e.addr, e.we, e.wstrb, e.data);
    endfunction

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h10:  rom = 32'h0050_0093;
            32'h14:  rom = 32'h0010_0113;
            32'h40:  rom = 32'h1234_5678;
            default: rom = 32'hBAD0_BAD0;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : lat
        localparam int L = g + 1;
        logic        rst_n = 1'b0;
        int          cyc = 0;
        ev_t         q[$];
        logic [31:0] pipe [4];

        mem_arbiter_if #(.AW(32), .DW(32)) bus ();
        mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.master)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // Memory: read data appears L cycles after the access cycle; non-read
        // cycles shift in all-ones so a leaked store response is visible.
        always @(posedge clk) begin
            pipe[0] <= (bus.mem_en && !bus.mem_we) ? rom(bus.mem_addr) : 32'hFFFF_FFFF;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign bus.mem_rdata = pipe[L-1];

        task automatic push(input logic [1:0] kind, input int c, input logic [31:0] addr,
                            input logic we, input logic [3:0] wstrb, input logic [31:0] data);
            ev_t e;
            e.kind  = kind;
            e.cyc   = c;
            e.addr  = addr;
            e.we    = we;
            e.wstrb = wstrb;
            e.data  = data;
            q.push_back(e);
        endtask

        task automatic go(input int t);
            while (cyc < t) begin
                @(posedge clk);
                #1;
            end
        endtask

        initial begin : stim
            int c;
            int t;
            bus.if_req  = 1'b1;
            bus.if_addr = 32'h10;
            bus.d_req   = 1'b1;
            bus.d_we    = 1'b0;
            bus.d_addr  = 32'h40;
            bus.d_wdata = 32'h0;
            bus.d_wstrb = 4'b0000;
            go(3);
            // contention straight out of reset: D first, then strict alternation
            rst_n = 1'b1;
            c = cyc;
            for (int k = 0; k < 4; k++) begin
                if (k % 2 == 0) begin
                    push(KD_G, c + k * (L + 1), 32'h40, 1'b0, 4'b0, 32'h0);
                    push(KD_R, c + k * (L + 1) + L, 32'h0, 1'b0, 4'b0, 32'h1234_5678);
                end else begin
                    push(KIF_G, c + k * (L + 1), 32'h10, 1'b0, 4'b0, 32'h0);
                    push(KIF_R, c + k * (L + 1) + L, 32'h0, 1'b0, 4'b0, 32'h0050_0093);
                end
            end
            go(c + 3 * (L + 1) + 1);
            bus.if_req = 1'b0;
            bus.d_req  = 1'b0;
            // single fetch
            t = c + 4 * (L + 1) + 1;
            go(t);
            bus.if_req  = 1'b1;
            bus.if_addr = 32'h10;
            push(KIF_G, t, 32'h10, 1'b0, 4'b0, 32'h0);
            push(KIF_R, t + L, 32'h0, 1'b0, 4'b0, 32'h0050_0093);
            go(t + 1);
            bus.if_req = 1'b0;
            // store
            t = t + L + 2;
            go(t);
            bus.d_req   = 1'b1;
            bus.d_we    = 1'b1;
            bus.d_addr  = 32'h80;
            bus.d_wdata = 32'hDEAD_BEEF;
            bus.d_wstrb = 4'b0011;
            push(KD_G, t, 32'h80, 1'b1, 4'b0011, 32'hDEAD_BEEF);
            push(KD_R, t + L, 32'h0, 1'b0, 4'b0, 32'h0);
            go(t + 1);
            bus.d_req   = 1'b0;
            bus.d_we    = 1'b0;
            bus.d_wdata = 32'h0;
            bus.d_wstrb = 4'b0000;
            // fetch raised while a load is in flight waits for the next idle cycle
            t = t + L + 2;
            go(t);
            bus.d_req  = 1'b1;
            bus.d_addr = 32'h40;
            push(KD_G, t, 32'h40, 1'b0, 4'b0, 32'h0);
            push(KD_R, t + L, 32'h0, 1'b0, 4'b0, 32'h1234_5678);
            go(t + 1);
            bus.d_req   = 1'b0;
            bus.if_req  = 1'b1;
            bus.if_addr = 32'h14;
            push(KIF_G, t + L + 1, 32'h14, 1'b0, 4'b0, 32'h0);
            push(KIF_R, t + 2 * L + 1, 32'h0, 1'b0, 4'b0, 32'h0010_0113);
            go(t + L + 2);
            bus.if_req = 1'b0;
            // reset one cycle after a data grant drops the response
            t = t + 2 * L + 3;
            go(t);
            bus.d_req  = 1'b1;
            bus.d_addr = 32'h40;
            push(KD_G, t, 32'h40, 1'b0, 4'b0, 32'h0);
            go(t + 1);
            rst_n       = 1'b0;
            bus.d_req   = 1'b0;
            bus.if_req  = 1'b1;
            bus.if_addr = 32'h10;
            go(t + 3);
            rst_n = 1'b1;
            push(KIF_G, t + 3, 32'h10, 1'b0, 4'b0, 32'h0);
            push(KIF_R, t + 3 + L, 32'h0, 1'b0, 4'b0, 32'h0050_0093);
            go(t + 4);
            bus.if_req = 1'b0;
            for (int i = 0; i < 16 && q.size() != 0; i++) @(posedge clk);
            go(cyc + 2);
            chk(q.size() == 0, $sformatf("L%0d drain: %0d events outstanding, required 0", L, q.size()));
            done++;
        end

        initial begin : mon
            logic gnt;
            logic rv;
            ev_t  act;
            ev_t  want;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    chk({bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata,
                         bus.mem_en, bus.mem_we, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata} == '0,
                        $sformatf("L%0d reset_quiet cyc %0d: gnt=%b/%b rvalid=%b/%b mem_en=%b addr=%h, required all 0",
                                  L, cyc, bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_addr));
                end else begin
                    gnt = bus.if_gnt || bus.d_gnt;
                    rv  = bus.if_rvalid || bus.d_rvalid;
                    chk((bus.if_rvalid || bus.if_rdata == '0) && (bus.d_rvalid || bus.d_rdata == '0) &&
                        (bus.mem_en || {bus.mem_we, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata} == '0) &&
                        bus.mem_en == gnt && !(gnt && rv) && !(bus.if_gnt && bus.d_gnt) &&
                        !(bus.if_rvalid && bus.d_rvalid),
                        $sformatf("L%0d quiet cyc %0d: gnt=%b/%b rvalid=%b/%b mem_en=%b we=%b strb=%b addr=%h wdata=%h rdata=%h/%h, required unused fields 0 and one event at most",
                                  L, cyc, bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we,
                                  bus.mem_wstrb, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata));
                    if (gnt || rv) begin
                        act.kind  = bus.if_gnt ? KIF_G : bus.d_gnt ? KD_G : bus.if_rvalid ? KIF_R : KD_R;
                        act.cyc   = cyc;
                        act.addr  = gnt ? bus.mem_addr : 32'h0;
                        act.we    = gnt ? bus.mem_we : 1'b0;
                        act.wstrb = gnt ? bus.mem_wstrb : 4'b0;
                        act.data  = gnt ? bus.mem_wdata : bus.if_rvalid ? bus.if_rdata : bus.d_rdata;
                        chk(q.size() != 0, $sformatf("L%0d unexpected event %s, required none", L, fmt(act)));
                        if (q.size() != 0) begin
                            want = q.pop_front();
                            chk(act == want, $sformatf("L%0d event: got %s, required %s", L, fmt(act), fmt(want)));
                        end
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 2000 && done < 4; i++) @(posedge clk);
        chk(done == 4, $sformatf("timeout: %0d of 4 sequences finished, required 4", done));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer that shares one single-port instruction/data memory between the rv32i fetch stage and its load/store unit. It accepts one transaction at a time, arbitrates round-robin on contention, drives the memory port, counts the fixed memory read latency, and routes the response back to the owning requester. It sits between the core (`rv32i`) and the unified memory, and enables the multi-cycle core variant.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width; must be 32, with 4 byte strobes.
- `MEM_LAT`, default 1: memory read latency in cycles, legal range 1..4.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  AW  fetch address.
- `if_gnt`  out  1  fetch request accepted (one-cycle pulse).
- `if_rvalid`  out  1  fetch response valid (one-cycle pulse).
- `if_rdata`  out  DW  fetch data; 0 when `if_rvalid`=0.
- `d_req`  in  1  data request; held with `d_we`, `d_addr`, `d_wdata`, `d_wstrb` until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  AW  data address.
- `d_wdata`  in  DW  store data.
- `d_wstrb`  in  4  store byte enables.
- `d_gnt`  out  1  data request accepted (one-cycle pulse).
- `d_rvalid`  out  1  data completion (load data or store ack).
- `d_rdata`  out  DW  load data; 0 for stores and when `d_rvalid`=0.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write.
- `mem_wstrb`  out  4  byte enables; 4'b0000 on reads.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, valid exactly `MEM_LAT` cycles after the `mem_en` cycle.

## Operation
- States: IDLE and BUSY. Registers: `owner` (IF/D), `is_wr`, 3-bit `lat_cnt`, `last` (last winner).
- IDLE: if any request is present, pick a winner.
  - Only one requester → that one wins.
  - Both requesting → the one not equal to `last` wins.
- The winner's `gnt`, `mem_en`, and `mem_*` fields are driven combinationally in the same cycle. At the clock edge: `owner` ← winner, `last` ← winner, `is_wr` ← (winner is D and `d_we`), `lat_cnt` ← 1, state ← BUSY.
- No request in IDLE: all outputs are 0 and the state holds.
- BUSY:
  - `mem_en` = 0 and both `gnt` = 0; requests are ignored and must remain held.
  - While `lat_cnt` < `MEM_LAT`: increment `lat_cnt`.
  - When `lat_cnt` == `MEM_LAT`: assert `owner`'s rvalid for this cycle, with rdata = `mem_rdata` (or 0 if `is_wr`). At the edge, state ← IDLE.
- Stores take the same latency as loads. The store ack is `d_rvalid` at issue+`MEM_LAT`.
- Memory fields (`mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`) are 0 whenever `mem_en` = 0.
- Fetch requests always have `mem_we` = 0 and `mem_wstrb` = 0.
- Reset (asynchronous, any state, including mid-transaction):
  - state = IDLE, `lat_cnt` = 0, `owner` = IF, `is_wr` = 0, `last` = IF, so D wins the first tie.
  - The in-flight response is dropped: no rvalid is issued after reset.
  - While `rst_n` = 0, every output is 0, even if requests are high.

## Timing
- Grant latency: 0 cycles from request in IDLE. The `gnt` cycle is the `mem_en` cycle (T).
- Response at cycle T+`MEM_LAT`.
- Next grant no earlier than T+`MEM_LAT`+1.
- Peak throughput: one transaction per `MEM_LAT`+1 cycles.
- Under continuous contention, grants strictly alternate IF, D, IF, … and no requester waits more than one transaction.
- A request that drops before `gnt` is simply not served. Requests deasserting during BUSY are legal and have no effect.
- `gnt` and rvalid are never asserted in the same cycle for the same requester.
- All outputs are combinational from the state registers and inputs. There is no combinational path from `mem_rdata` to anything except `if_rdata` and `d_rdata`.

## Test plan
- **Reset, both requesting (`MEM_LAT`=2):** reset, then `if_req`=`d_req`=1 from cycle 0. Expect `d_gnt` at cycle 0, `d_rvalid` at 2, `if_gnt` at 3, `if_rvalid` at 5, `d_gnt` at 6; grants alternate thereafter.
- **Single fetch (`MEM_LAT`=1):** `if_addr`=0x10, `mem_rdata`=0x00500093 at issue+1. Expect `mem_en`=1, `mem_addr`=0x10, `mem_we`=0 at T; `if_rvalid`=1 and `if_rdata`=0x00500093 at T+1; `d_rvalid` stays 0.
- **Store:** `d_we`=1, `d_addr`=0x80, `d_wdata`=0xDEADBEEF, `d_wstrb`=4'b0011. Expect `mem_we`=1, `mem_wstrb`=0011, `mem_wdata`=0xDEADBEEF at T; `d_rvalid`=1 and `d_rdata`=0 at T+`MEM_LAT`.
- **Reset mid-transaction:** assert `rst_n`=0 one cycle after `d_gnt` (`MEM_LAT`=3). Expect all outputs 0 immediately and no `d_rvalid` afterwards. After release with `if_req` high, expect `if_gnt` the same cycle.
- **Request held during BUSY:** `if_req` rises at T+1 while D is in flight (`MEM_LAT`=2). Expect no `if_gnt` until T+3, then `mem_addr`=`if_addr`.
- **Latency sweep:** `MEM_LAT`=1,2,3,4. Expect rvalid exactly `MEM_LAT` cycles after `gnt` in every case; there is never a cycle with both `mem_en` and rvalid asserted.
